// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame geometry and
// the 3-sample majority vote used by the receive sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OVERSAMPLE = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side bus of uart_rx_core: serial line in, received words and strobes out.
// Parity signals exist only when UART_RX_PARITY_EN is defined.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH
);
    logic                  i_rx_in;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_valid;
    logic                  o_stop_err;
    logic                  o_busy;
`ifdef UART_RX_PARITY_EN
    logic                  i_par_type;
    logic                  o_parity_err;

    modport master (input i_rx_in, input i_par_type,
                    output o_data, output o_data_valid, output o_stop_err,
                    output o_parity_err, output o_busy);
    modport slave  (output i_rx_in, output i_par_type,
                    input o_data, input o_data_valid, input o_stop_err,
                    input o_parity_err, input o_busy);
`else
    modport master (input i_rx_in,
                    output o_data, output o_data_valid, output o_stop_err,
                    output o_busy);
    modport slave  (output i_rx_in,
                    input o_data, input o_data_valid, input o_stop_err,
                    input o_busy);
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// In-bit oversample counter with wrap, bit tick and the 3-sample majority
// around mid-bit; the vote is valid in the cycle where sample_tick is high.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic CLK,
    input  logic RST,
    input  logic rx_s,
    input  logic cnt_clr,
    output logic bit_tick,
    output logic sample_tick,
    output logic bit_val
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] SMP_LO   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SMP_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SMP_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             smp_lo_r;
    logic             smp_mid_r;

    // Up-counter that wraps at the bit boundary or restarts on request.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr || (cnt_r == CNT_LAST)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Capture the two early votes; the third is the live line at SMP_HI.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            smp_lo_r  <= 1'b1;
            smp_mid_r <= 1'b1;
        end else begin
            if (cnt_r == SMP_LO)  smp_lo_r  <= rx_s;
            if (cnt_r == SMP_MID) smp_mid_r <= rx_s;
        end
    end

    assign bit_tick    = (cnt_r == CNT_LAST);
    assign sample_tick = (cnt_r == SMP_HI);
    assign bit_val     = maj3(smp_lo_r, smp_mid_r, rx_s);

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start / DATA_WIDTH data bits LSB first / stop.
// Define UART_RX_PARITY_EN to add a parity bit with even/odd selection.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_core_if.master bus
);
    localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    uart_state_e           state_r, state_nxt_s;
    logic                  sync1_r, rx_s_r;
    logic                  bit_tick_s, sample_tick_s, bit_val_s;
    logic                  cnt_clr_s, shift_en_s, idx_inc_s, idx_clr_s;
    logic                  word_ok_s, stop_bad_s;
    logic [DATA_WIDTH-1:0] shift_r, data_r;
    logic [IDX_W-1:0]      bit_idx_r;
    logic                  data_valid_r, stop_err_r;
`ifdef UART_RX_PARITY_EN
    logic                  par_chk_s, par_pulse_s, par_bad_r, parity_err_r;

    function automatic logic word_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_r <= 1'b1;
            rx_s_r  <= 1'b1;
        end else begin
            sync1_r <= bus.i_rx_in;
            rx_s_r  <= sync1_r;
        end
    end

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx_s        (rx_s_r),
        .cnt_clr     (cnt_clr_s),
        .bit_tick    (bit_tick_s),
        .sample_tick (sample_tick_s),
        .bit_val     (bit_val_s)
    );

    // Frame state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_r <= IDLE;
        else      state_r <= state_nxt_s;
    end

    // Next state and datapath controls; STOP exits at mid-bit to catch back-to-back frames.
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        idx_inc_s   = 1'b0;
        idx_clr_s   = 1'b0;
        word_ok_s   = 1'b0;
        stop_bad_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk_s   = 1'b0;
        par_pulse_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (rx_s_r == 1'b0) begin
                    state_nxt_s = START;
                    idx_clr_s   = 1'b1;
                end else begin
                    cnt_clr_s   = 1'b1;
                end
            end
            START: begin
                if (sample_tick_s && bit_val_s) begin
                    state_nxt_s = IDLE;
                    cnt_clr_s   = 1'b1;
                end else if (bit_tick_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                shift_en_s = sample_tick_s;
                if (bit_tick_s) begin
                    if (bit_idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        idx_inc_s = 1'b1;
                    end
                end else begin
                    idx_inc_s = 1'b0;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                par_chk_s = sample_tick_s;
                if (bit_tick_s) state_nxt_s = STOP;
                else            state_nxt_s = PARITY;
            end
`endif
            STOP: begin
                if (sample_tick_s) begin
                    state_nxt_s = IDLE;
                    cnt_clr_s   = 1'b1;
                    stop_bad_s  = ~bit_val_s;
`ifdef UART_RX_PARITY_EN
                    word_ok_s   = bit_val_s & ~par_bad_r;
                    par_pulse_s = par_bad_r;
`else
                    word_ok_s   = bit_val_s;
`endif
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_clr_s   = 1'b1;
            end
        endcase
    end

    // Shift register, bit index and registered word/strobe outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_r      <= {DATA_WIDTH{1'b0}};
            bit_idx_r    <= {IDX_W{1'b0}};
            data_r       <= {DATA_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            stop_err_r   <= 1'b0;
        end else begin
            if (shift_en_s) shift_r[bit_idx_r] <= bit_val_s;
            if (idx_clr_s)      bit_idx_r <= {IDX_W{1'b0}};
            else if (idx_inc_s) bit_idx_r <= bit_idx_r + IDX_ONE;
            if (word_ok_s) data_r <= shift_r;
            data_valid_r <= word_ok_s;
            stop_err_r   <= stop_bad_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch latched per frame and reported at the stop decision.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (idx_clr_s)      par_bad_r <= 1'b0;
            else if (par_chk_s) par_bad_r <= bit_val_s ^ word_parity(shift_r) ^ bus.i_par_type;
            parity_err_r <= par_pulse_s;
        end
    end

    assign bus.o_parity_err = parity_err_r;
`endif

    assign bus.o_data       = data_r;
    assign bus.o_data_valid = data_valid_r;
    assign bus.o_stop_err   = stop_err_r;
    assign bus.o_busy       = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomized frames for uart_rx_core, checked against a frame-level
// model of expected events (kind, word, cycle). Honours UART_RX_PARITY_EN.
module tb_uart_rx_core;
    localparam int DW = 8;
    localparam int OS = 8;
    localparam int H  = OS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    typedef struct {
        int         kind;   // 0 word, 1 stop error, 2 parity error
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc   = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_data = 8'h00;
    logic       par_type = 1'b0;
    ev_t        exp_q[$];
    ev_t        obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_core_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_core #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.master)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_data_valid) obs_q.push_back('{0, bus.o_data, cyc});
            if (bus.o_stop_err)   obs_q.push_back('{1, 8'h00, cyc});
`ifdef UART_RX_PARITY_EN
            if (bus.o_parity_err) obs_q.push_back('{2, 8'h00, cyc});
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 bus.i_rx_in = 1'b1;
        end
    endtask

    // One frame; gl_bit >= 0 inverts data bit gl_bit for the single cycle gl_off.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input int gl_bit, input int gl_off, input int gap);
        logic line [NB];
        logic par_bad;
        int   start_c;
        int   ecyc;
        line[0] = 1'b0;
        for (int i = 0; i < DW; i++) line[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
        line[DW + 1] = (^d) ^ par_type ^ par_flip;
        par_bad = par_flip;
        bus.i_par_type = par_type;
`else
        par_bad = 1'b0;
`endif
        line[NB - 1] = stop_b;
        start_c = 0;
        for (int b = 0; b < NB; b++) begin
            for (int o = 0; o < OS; o++) begin
                @(posedge clk);
                #1;
                if (b == 0 && o == 0) start_c = cyc;
                bus.i_rx_in = line[b] ^ ((gl_bit >= 0 && b == gl_bit + 1 && o == gl_off) ? 1'b1 : 1'b0);
            end
        end
        ecyc = start_c + OS * (NB - 1) + H + 1 + 3;
        if (stop_b && !par_bad) begin
            exp_q.push_back('{0, d, ecyc});
            exp_data = d;
        end
        if (!stop_b) exp_q.push_back('{1, 8'h00, ecyc});
        if (par_bad) exp_q.push_back('{2, 8'h00, ecyc});
        idle(gap);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs;
        logic       rp;
        int         gb;
        int         n;
        bus.i_rx_in = 1'b1;
`ifdef UART_RX_PARITY_EN
        bus.i_par_type = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  bus.o_data, 8'h00);
        chk("rst_valid", bus.o_data_valid, 1'b0);
        chk("rst_stop",  bus.o_stop_err, 1'b0);
        chk("rst_busy",  bus.o_busy, 1'b0);
`ifdef UART_RX_PARITY_EN
        chk("rst_par",   bus.o_parity_err, 1'b0);
`endif
        rst_n = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, -1, 0, 10);
        chk("a5_data", bus.o_data, exp_data);

        // two-cycle low glitch on the idle line
        @(posedge clk); #1 bus.i_rx_in = 1'b0;
        @(posedge clk); #1 bus.i_rx_in = 1'b0;
        @(posedge clk); #1 bus.i_rx_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_hi", bus.o_busy, 1'b1);
        idle(8);
        chk("glitch_busy_lo", bus.o_busy, 1'b0);
        chk("glitch_no_event", obs_q.size(), exp_q.size());
        send_frame(8'h3C, 1'b1, 1'b0, -1, 0, 10);

        send_frame(8'h81, 1'b0, 1'b0, -1, 0, 20);
        chk("stop_err_hold", bus.o_data, 8'h3C);
        send_frame(8'h7E, 1'b1, 1'b0, -1, 0, 10);

        send_frame(8'h00, 1'b1, 1'b0, -1, 0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, -1, 0, 10);
        chk("b2b_data", bus.o_data, 8'hFF);

        send_frame(8'h55, 1'b1, 1'b0, 3, H, 10);
        chk("maj_data", bus.o_data, 8'h55);

        // reset in the middle of data bits of 0xC3
        for (int b = 0; b < 4; b++) begin
            for (int o = 0; o < OS; o++) begin
                @(posedge clk);
                #1 bus.i_rx_in = (b == 0) ? 1'b0 : ((b == 3) ? 1'b0 : 1'b1);
            end
        end
        chk("pre_rst_busy", bus.o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        chk("midrst_data",  bus.o_data, exp_data);
        chk("midrst_valid", bus.o_data_valid, 1'b0);
        chk("midrst_stop",  bus.o_stop_err, 1'b0);
        chk("midrst_busy",  bus.o_busy, 1'b0);
        bus.i_rx_in = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(4);
        send_frame(8'h12, 1'b1, 1'b0, -1, 0, 10);
        chk("post_rst_data", bus.o_data, 8'h12);

`ifdef UART_RX_PARITY_EN
        par_type = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, -1, 0, 10);
        chk("par_ok_data", bus.o_data, 8'h5A);
        send_frame(8'hC6, 1'b1, 1'b0, -1, 0, 10);
        send_frame(8'h5A, 1'b1, 1'b1, -1, 0, 10);
        chk("par_bad_hold", bus.o_data, 8'hC6);
`endif

        for (int k = 0; k < 16; k++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(3) != 0);
`ifdef UART_RX_PARITY_EN
            rp = ($urandom_range(3) == 0);
            par_type = 1'($urandom);
`else
            rp = 1'b0;
`endif
            gb = $urandom_range(DW);
            if (gb == DW) gb = -1;
            send_frame(rd, rs, rp, gb, $urandom_range(OS - 1),
                       rs ? $urandom_range(6) : $urandom_range(24, 16));
        end

        idle(120);
        chk("final_data", bus.o_data, exp_data);
        chk("n_events", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("ev%0d_kind", i), obs_q[i].kind, exp_q[i].kind);
            chk($sformatf("ev%0d_data", i), obs_q[i].data, exp_q[i].data);
            chk($sformatf("ev%0d_cyc", i),  obs_q[i].cyc,  exp_q[i].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
